// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with stall, jump, relative branch and a
// call/return LIFO; stack overflow/underflow raise sticky error flags.
module pc_stack_unit #(
  parameter int WIDTH       = 8,
  parameter int OFF_WIDTH   = 8,
  parameter int INC         = 1,
  parameter int RESET_ADDR  = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic                               jump,
  input  logic [WIDTH-1:0]                   jump_addr,
  input  logic                               branch,
  input  logic [OFF_WIDTH-1:0]               branch_off,
  input  logic                               call,
  input  logic [WIDTH-1:0]                   call_addr,
  input  logic                               ret,
  output logic [WIDTH-1:0]                   pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               ovf_err,
  output logic                               unf_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SLOTS = 1 << IDX_W;
  localparam logic [WIDTH-1:0] INC_V  = WIDTH'(INC);
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_ADDR);
  localparam logic [SP_W-1:0]  SP_MAX = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]  SP_ONE = SP_W'(1);

  logic [WIDTH-1:0] pc_r;
  logic [SP_W-1:0]  sp_r;
  logic             ovf_r;
  logic             unf_r;
  logic [WIDTH-1:0] stack_r [SLOTS];

  logic [WIDTH-1:0] pc_nxt_s;
  logic [SP_W-1:0]  sp_nxt_s;
  logic             push_s;
  logic             ovf_set_s;
  logic             unf_set_s;
  logic             full_s;
  logic             empty_s;
  logic [WIDTH-1:0] off_ext_s;
  logic [WIDTH-1:0] ret_addr_s;
  logic [IDX_W-1:0] top_idx_s;
  logic [IDX_W-1:0] wr_idx_s;

  assign full_s     = (sp_r == SP_MAX);
  assign empty_s    = (sp_r == {SP_W{1'b0}});
  // Size cast of a signed operand sign-extends, also when OFF_WIDTH == WIDTH.
  assign off_ext_s  = WIDTH'($signed(branch_off));
  assign ret_addr_s = pc_r + INC_V;
  assign top_idx_s  = IDX_W'(sp_r - SP_ONE);
  assign wr_idx_s   = IDX_W'(sp_r);

  // Next pc/sp and error events, one action per cycle in priority order.
  always_comb begin
    pc_nxt_s  = pc_r;
    sp_nxt_s  = sp_r;
    push_s    = 1'b0;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    if (stall) begin
      pc_nxt_s = pc_r;
    end else if (ret) begin
      if (!empty_s) begin
        pc_nxt_s = stack_r[top_idx_s];
        sp_nxt_s = sp_r - SP_ONE;
      end else begin
        unf_set_s = 1'b1;
      end
    end else if (call) begin
      if (!full_s) begin
        push_s   = 1'b1;
        pc_nxt_s = call_addr;
        sp_nxt_s = sp_r + SP_ONE;
      end else begin
        ovf_set_s = 1'b1;
      end
    end else if (jump) begin
      pc_nxt_s = jump_addr;
    end else if (branch) begin
      pc_nxt_s = pc_r + off_ext_s;
    end else begin
      pc_nxt_s = pc_r + INC_V;
    end
  end

  // Control state register with synchronous reset and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r  <= RST_V;
      sp_r  <= {SP_W{1'b0}};
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      pc_r  <= pc_nxt_s;
      sp_r  <= sp_nxt_s;
      ovf_r <= ovf_r | ovf_set_s;
      unf_r <= unf_r | unf_set_s;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      stack_r[wr_idx_s] <= ret_addr_s;
    end
  end

  assign pc          = pc_r;
  assign sp          = sp_r;
  assign stack_full  = full_s;
  assign stack_empty = empty_s;
  assign ovf_err     = ovf_r;
  assign unf_err     = unf_r;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: directed plan plus random stimulus
// checked against a queue-based reference model.
module tb_pc_stack_unit;

  logic       clk;
  logic       reset;
  logic       stall;
  logic       jump;
  logic [7:0] jump_addr;
  logic       branch;
  logic [7:0] branch_off;
  logic       call;
  logic [7:0] call_addr;
  logic       ret;
  logic [7:0] pc;
  logic [2:0] sp;
  logic       stack_full;
  logic       stack_empty;
  logic       ovf_err;
  logic       unf_err;

  typedef struct packed {
    logic [7:0] pc;
    logic [2:0] sp;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_ovf;
  bit m_unf;

  pc_stack_unit #(
    .WIDTH(8), .OFF_WIDTH(8), .INC(1), .RESET_ADDR(0), .STACK_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .jump_addr(jump_addr),
    .branch(branch), .branch_off(branch_off), .call(call), .call_addr(call_addr),
    .ret(ret), .pc(pc), .sp(sp), .stack_full(stack_full), .stack_empty(stack_empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input bit r, input bit s, input bit rt, input bit c,
                      input bit j, input bit b, input logic [7:0] ja,
                      input logic [7:0] ca, input logic [7:0] bo);
    obs_t e;
    int   off;
    @(negedge clk);
    reset = r; stall = s; ret = rt; call = c; jump = j; branch = b;
    jump_addr = ja; call_addr = ca; branch_off = bo;
    off = int'($signed(bo));
    if (r) begin
      m_pc = 0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (s) begin
      m_pc = m_pc;
    end else if (rt) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else m_unf = 1'b1;
    end else if (c) begin
      if (m_stk.size() < 4) begin
        m_stk.push_back((m_pc + 1) % 256);
        m_pc = int'(ca);
      end else begin
        m_ovf = 1'b1;
      end
    end else if (j) begin
      m_pc = int'(ja);
    end else if (b) begin
      m_pc = (m_pc + off + 256) % 256;
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
    e.pc    = 8'(m_pc);
    e.sp    = 3'(m_stk.size());
    e.full  = (m_stk.size() == 4);
    e.empty = (m_stk.size() == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  // Monitor: every edge that has a pending expectation is compared
  always @(posedge clk) begin
    obs_t e;
    obs_t a;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pc, sp, stack_full, stack_empty, ovf_err, unf_err};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL state t=%0t got pc=%h sp=%0d full=%b empty=%b ovf=%b unf=%b want pc=%h sp=%0d full=%b empty=%b ovf=%b unf=%b",
                 $time, a.pc, a.sp, a.full, a.empty, a.ovf, a.unf,
                 e.pc, e.sp, e.full, e.empty, e.ovf, e.unf);
      end
    end
  end

  initial begin
    reset = 1'b0; stall = 1'b0; ret = 1'b0; call = 1'b0; jump = 1'b0; branch = 1'b0;
    jump_addr = 8'h00; call_addr = 8'h00; branch_off = 8'h00;
    m_pc = 0; m_ovf = 1'b0; m_unf = 1'b0;

    // 1: reset, idle count, wrap at 0xFF
    step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    idle(10);
    step(0, 0, 0, 0, 1, 0, 8'hFE, 8'h00, 8'h00);
    idle(2);
    // 2: jump, branch -4, jump beats branch, negative wrap
    step(0, 0, 0, 0, 1, 0, 8'h10, 8'h00, 8'h00);
    step(0, 0, 0, 0, 1, 0, 8'hA5, 8'h00, 8'h00);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'hFC);
    step(0, 0, 0, 0, 1, 1, 8'h33, 8'h00, 8'h7F);
    step(0, 0, 0, 0, 1, 0, 8'h02, 8'h00, 8'h00);
    step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'hFC);
    // 3: nested call and returns
    step(0, 0, 0, 0, 1, 0, 8'h20, 8'h00, 8'h00);
    step(0, 0, 0, 1, 0, 0, 8'h00, 8'h80, 8'h00);
    idle(2);
    step(0, 0, 0, 1, 0, 0, 8'h00, 8'hC0, 8'h00);
    step(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    step(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    // 4: five calls overflow the four-entry stack, then ret
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 8'h00, 8'(8'h40 + 8'(i * 16)), 8'h00);
    step(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    // 5: drain to underflow, then stall with jump
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0, 8'hEE, 8'h00, 8'h00);
    idle(1);
    // 6: reset overrides a call with sp=2 and both flags set
    step(0, 0, 0, 1, 0, 0, 8'h00, 8'h50, 8'h00);
    step(0, 0, 0, 1, 0, 0, 8'h00, 8'h60, 8'h00);
    step(1, 0, 0, 1, 0, 0, 8'h00, 8'h70, 8'h00);
    idle(1);

    // Random phase
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           8'($urandom), 8'($urandom), 8'($urandom));
    end
    idle(1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program counter that extends the 8-bit PC with configurable width, reset vector and increment step.
- Adds new control: stall, PC-relative branch, and call/return through an internal LIFO return-address stack.
- Sits in the fetch stage and drives the instruction-memory address every cycle.
- Overflow and underflow of the return stack are reported through sticky error flags.

Parameters:
- WIDTH, 8: PC and address width in bits (4..32).
- OFF_WIDTH, 8: width of the signed branch offset (2..WIDTH).
- INC, 1: sequential increment step added to pc.
- RESET_ADDR, 0: value of pc after reset.
- STACK_DEPTH, 4: return-stack entries (1..16).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold pc and stack this cycle.
- jump  input  1  absolute jump request.
- jump_addr  input  WIDTH  absolute jump target.
- branch  input  1  relative branch request.
- branch_off  input  OFF_WIDTH  two's-complement offset, relative to current pc.
- call  input  1  push return address, then go to call_addr.
- call_addr  input  WIDTH  subroutine target.
- ret  input  1  pop return address into pc.
- pc  output  WIDTH  current program counter (registered).
- sp  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  output  1  combinational, sp == STACK_DEPTH.
- stack_empty  output  1  combinational, sp == 0.
- ovf_err  output  1  sticky: a call was attempted while full.
- unf_err  output  1  sticky: a ret was attempted while empty.

Behaviour:
- All state updates occur on posedge clk only. pc is registered, so a request sampled at edge N is visible on pc after edge N.
- Reset (synchronous, active-high):
  - pc = RESET_ADDR, sp = 0, ovf_err = 0, unf_err = 0.
  - Stack contents are don't-care.
  - Reset overrides every other input, including a call or ret in progress.
- Priority for each non-reset edge (one action per cycle):
  1. stall
  2. ret
  3. call
  4. jump
  5. branch
  6. sequential increment
- stall=1: pc, sp and the stack hold; all other requests that cycle are ignored and not queued.
- ret:
  - If sp>0: pc <= stack[sp-1]; sp <= sp-1.
  - If sp==0: pc holds, sp stays 0, unf_err <= 1.
- call:
  - If sp<STACK_DEPTH: stack[sp] <= pc+INC; sp <= sp+1; pc <= call_addr.
  - If full: pc holds, stack untouched, ovf_err <= 1.
- jump: pc <= jump_addr.
- branch: pc <= pc + sign_extend(branch_off).
- Otherwise: pc <= pc + INC.
- Arithmetic: all pc arithmetic is modulo 2^WIDTH.
  - Increment past max wraps, e.g. WIDTH=8: 0xFF+1 -> 0x00.
  - Negative branches wrap, e.g. 0x02 + (-4) -> 0xFE.
  - The pushed return address pc+INC also wraps.
- Error flags are sticky. They clear only on reset and do not block later valid operations.
- stack_full and stack_empty are pure decodes of sp. They are never both 1 (STACK_DEPTH>=1).

Test Plan:
1. Reset, then 10 idle cycles (WIDTH=8, INC=1, RESET_ADDR=0) -> pc steps 0x00..0x0A; at pc=0xFF the next edge gives 0x00.
2. At pc=0x10: jump with jump_addr=0xA5 -> pc=0xA5, then 0xA6. Then branch with branch_off=8'hFC (-4) -> pc=0xA2 (0xA6-4). Jump and branch asserted together -> jump wins.
3. At pc=0x20: call with call_addr=0x80 -> pc=0x80, sp=1. Nested call at pc=0x82 with call_addr=0xC0 -> sp=2. Then ret -> pc=0x83; ret -> pc=0x21, sp=0, stack_empty=1.
4. STACK_DEPTH=4: five consecutive calls -> sp=4, stack_full=1; fifth call leaves pc unchanged and sets ovf_err=1. Then ret -> pc = return address of the fourth call, sp=3, ovf_err still 1.
5. ret with sp=0 -> pc holds, unf_err=1. Then stall=1 together with jump for 3 cycles -> pc and sp frozen, no jump taken after stall drops.
6. Reset asserted in the same cycle as call with sp=2 and both error flags set -> next cycle pc=RESET_ADDR, sp=0, ovf_err=0, unf_err=0.
